// File: rtl/givens_q_accum_if.sv
`default_nettype none
// ============================================================================
// Module   : givens_q_accum_if
// Brief    : Control, rotation and readout bundle for givens_q_accum.
// Revision : 1.0
// ============================================================================
interface givens_q_accum_if #(
    parameter int N    = 4,
    parameter int SIZE = 16
);
    localparam int c_pw = $clog2(N);

    logic                   init;
    logic                   rot_valid;
    logic                   rot_ready;
    logic [c_pw-1:0]        p;
    logic [c_pw-1:0]        q;
    logic signed [SIZE-1:0] cos;
    logic signed [SIZE-1:0] sin;
    logic                   read;
    logic                   done;
    logic                   err;
    logic signed [SIZE-1:0] q_out;
    logic                   q_valid;
    logic                   finish;

    modport master (
        output init, rot_valid, p, q, cos, sin, read,
        input  rot_ready, done, err, q_out, q_valid, finish
    );

    modport slave (
        input  init, rot_valid, p, q, cos, sin, read,
        output rot_ready, done, err, q_out, q_valid, finish
    );
endinterface
`default_nettype wire

// File: rtl/givens_q_accum.sv
`default_nettype none
// ============================================================================
// Module   : givens_q_accum
// Brief    : Accumulates Givens rotations into an N x N fixed-point Q matrix,
//            one row per cycle, with a row-major streaming readout.
// Revision : 1.0
// ============================================================================
module givens_q_accum #(
    parameter int N    = 4,
    parameter int SIZE = 16,
    parameter int FRAC = 12
) (
    input  logic            clk,
    input  logic            rst,
    givens_q_accum_if.slave bus
);
    localparam int c_pw = $clog2(N);
    localparam int c_rw = $clog2(N + 1);
    localparam int c_w2 = 2 * SIZE + 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_rot  = 2'd1;
    localparam logic [1:0] c_read = 2'd2;

    localparam logic signed [SIZE-1:0] c_one  = SIZE'(1 << FRAC);
    localparam logic signed [SIZE-1:0] c_smax = {1'b0, {(SIZE-1){1'b1}}};
    localparam logic signed [SIZE-1:0] c_smin = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic signed [c_w2-1:0] c_max  = {{(SIZE+2){1'b0}}, {(SIZE-1){1'b1}}};
    localparam logic signed [c_w2-1:0] c_min  = {{(SIZE+2){1'b1}}, {(SIZE-1){1'b0}}};

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [c_rw-1:0]        r_row;
    logic [c_pw-1:0]        r_pi;
    logic [c_pw-1:0]        r_qi;
    logic [c_pw-1:0]        r_rd_row;
    logic [c_pw-1:0]        r_rd_col;
    logic signed [SIZE-1:0] r_cos;
    logic signed [SIZE-1:0] r_sin;
    logic signed [SIZE-1:0] r_mat [N][N];

    logic                   r_done, r_err, r_finish, r_q_valid;
    logic signed [SIZE-1:0] r_q_out;
    logic                   w_done_nxt, w_err_nxt, w_finish_nxt, w_q_valid_nxt;
    logic signed [SIZE-1:0] w_q_out_nxt;

    logic w_idle, w_init_go, w_rot_hs, w_oob, w_bad, w_rot_go, w_rot_err, w_read_go;
    logic w_row_end, w_rd_last;

    function automatic logic signed [SIZE-1:0] f_sat(input logic signed [c_w2-1:0] v);
        if (v > c_max)
            f_sat = c_smax;
        else if (v < c_min)
            f_sat = c_smin;
        else
            f_sat = v[SIZE-1:0];
    endfunction

    // Priority init > rotation > read is resolved here; losers are dropped.
    assign w_idle    = (r_state == c_idle);
    assign w_init_go = w_idle & bus.init;
    assign w_rot_hs  = w_idle & ~bus.init & bus.rot_valid;
    assign w_bad     = (bus.p == bus.q) | w_oob;
    assign w_rot_go  = w_rot_hs & ~w_bad;
    assign w_rot_err = w_rot_hs & w_bad;
    assign w_read_go = w_idle & ~bus.init & ~bus.rot_valid & bus.read;

    generate
        if ((1 << c_pw) == N) begin : g_pow2
            assign w_oob = 1'b0;
        end else begin : g_npow2
            assign w_oob = (int'(bus.p) >= N) || (int'(bus.q) >= N);
        end
    endgenerate

    assign w_row_end = (r_state == c_rot) && (r_row == c_rw'(N));
    assign w_rd_last = (r_state == c_read) && (r_rd_row == c_pw'(N - 1))
                       && (r_rd_col == c_pw'(N - 1));

    // Row datapath: both products pairs use the pre-update values of the row.
    logic [c_pw-1:0]          w_ri;
    logic signed [SIZE-1:0]   w_a, w_b;
    logic signed [2*SIZE-1:0] w_ca, w_sb, w_sa, w_cb;
    logic signed [c_w2-1:0]   w_sum_p, w_sum_q, w_shp, w_shq;
    logic signed [SIZE-1:0]   w_new_p, w_new_q;

    assign w_ri    = r_row[c_pw-1:0];
    assign w_a     = r_mat[w_ri][r_pi];
    assign w_b     = r_mat[w_ri][r_qi];
    assign w_ca    = r_cos * w_a;
    assign w_sb    = r_sin * w_b;
    assign w_sa    = r_sin * w_a;
    assign w_cb    = r_cos * w_b;
    assign w_sum_p = {w_ca[2*SIZE-1], w_ca} - {w_sb[2*SIZE-1], w_sb};
    assign w_sum_q = {w_sa[2*SIZE-1], w_sa} + {w_cb[2*SIZE-1], w_cb};
    assign w_shp   = w_sum_p >>> FRAC;
    assign w_shq   = w_sum_q >>> FRAC;
    assign w_new_p = f_sat(w_shp);
    assign w_new_q = f_sat(w_shq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= c_idle;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle: begin
                if (w_rot_go)
                    w_state_nxt = c_rot;
                else if (w_read_go)
                    w_state_nxt = c_read;
            end
            c_rot:   if (w_row_end) w_state_nxt = c_idle;
            c_read:  if (w_rd_last) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        w_done_nxt    = w_row_end;
        w_err_nxt     = w_rot_err;
        w_finish_nxt  = w_rd_last;
        w_q_valid_nxt = w_read_go | (r_state == c_read);
        w_q_out_nxt   = r_q_out;
        if (w_read_go)
            w_q_out_nxt = r_mat[0][0];
        else if (r_state == c_read)
            w_q_out_nxt = r_mat[r_rd_row][r_rd_col];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_finish  <= 1'b0;
            r_q_valid <= 1'b0;
            r_q_out   <= '0;
        end else begin
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_finish  <= w_finish_nxt;
            r_q_valid <= w_q_valid_nxt;
            r_q_out   <= w_q_out_nxt;
        end
    end

    // Readout emits element [0][0] on the start edge, so the walk begins at [0][1].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row    <= '0;
            r_pi     <= '0;
            r_qi     <= '0;
            r_cos    <= '0;
            r_sin    <= '0;
            r_rd_row <= '0;
            r_rd_col <= '0;
        end else begin
            if (w_rot_go) begin
                r_pi  <= bus.p;
                r_qi  <= bus.q;
                r_cos <= bus.cos;
                r_sin <= bus.sin;
                r_row <= '0;
            end else if (r_state == c_rot && !w_row_end) begin
                r_row <= r_row + c_rw'(1);
            end
            if (w_read_go) begin
                r_rd_row <= '0;
                r_rd_col <= c_pw'(1);
            end else if (r_state == c_read) begin
                if (r_rd_col == c_pw'(N - 1)) begin
                    r_rd_col <= '0;
                    r_rd_row <= r_rd_row + c_pw'(1);
                end else begin
                    r_rd_col <= r_rd_col + c_pw'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    r_mat[i][j] <= (i == j) ? c_one : '0;
        end else if (w_init_go) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    r_mat[i][j] <= (i == j) ? c_one : '0;
        end else if (r_state == c_rot && !w_row_end) begin
            r_mat[w_ri][r_pi] <= w_new_p;
            r_mat[w_ri][r_qi] <= w_new_q;
        end
    end

    assign bus.rot_ready = w_idle;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.finish    = r_finish;
    assign bus.q_valid   = r_q_valid;
    assign bus.q_out     = r_q_out;
endmodule
`default_nettype wire

// File: tb/tb_givens_q_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_givens_q_accum
// Brief    : Self-checking bench for givens_q_accum with a readout scoreboard.
// Revision : 1.0
// ============================================================================
module tb_givens_q_accum;
    localparam int N    = 4;
    localparam int SIZE = 16;
    localparam int FRAC = 12;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    givens_q_accum_if #(.N(N), .SIZE(SIZE)) bus ();

    givens_q_accum #(.N(N), .SIZE(SIZE), .FRAC(FRAC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int m [N][N];
    logic signed [SIZE-1:0] exp_q [$];

    function automatic int sat16(input longint v);
        if (v > 32767)  return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    task automatic model_identity();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                m[i][j] = (i == j) ? (1 << FRAC) : 0;
    endtask

    task automatic model_rotate(input int p, input int q, input int c, input int s);
        for (int r = 0; r < N; r++) begin
            longint a, b;
            a = m[r][p];
            b = m[r][q];
            m[r][p] = sat16((longint'(c) * a - longint'(s) * b) >>> FRAC);
            m[r][q] = sat16((longint'(s) * a + longint'(c) * b) >>> FRAC);
        end
    endtask

    // Scoreboard: each streamed element is compared with the next expected one.
    always @(negedge clk) begin
        logic signed [SIZE-1:0] e;
        if (bus.q_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream_extra: got element %h, expected none", bus.q_out);
            end else begin
                e = exp_q.pop_front();
                if (bus.q_out !== e) begin
                    errors++;
                    $display("FAIL stream_elem: got %h, expected %h", bus.q_out, e);
                end
            end
        end
    end

    task automatic do_init();
        @(negedge clk);
        bus.init = 1'b1;
        @(negedge clk);
        bus.init = 1'b0;
        model_identity();
    endtask

    task automatic run_read(input string tag);
        int cnt;
        logic signed [SIZE-1:0] last;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                exp_q.push_back(SIZE'(m[i][j]));
        last = SIZE'(m[N-1][N-1]);
        @(negedge clk);
        bus.read = 1'b1;
        @(negedge clk);
        bus.read = 1'b0;
        cnt = 0;
        for (int k = 0; k < 3 * N * N; k++) begin
            if (bus.q_valid === 1'b1) begin
                cnt++;
                checks++;
                if (bus.finish !== 1'(cnt == N * N)) begin
                    errors++;
                    $display("FAIL %s finish: got %b at element %0d", tag, bus.finish, cnt);
                end
            end else if (cnt > 0) begin
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (cnt !== N * N) begin
            errors++;
            $display("FAIL %s valid_count: got %0d, expected %0d", tag, cnt, N * N);
        end
        checks++;
        if (bus.q_out !== last) begin
            errors++;
            $display("FAIL %s q_out_hold: got %h, expected %h", tag, bus.q_out, last);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s leftover: got %0d unread, expected 0", tag, exp_q.size());
        end
        exp_q.delete();
        checks++;
        if (bus.rot_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_after_read: got %b, expected 1", tag, bus.rot_ready);
        end
    endtask

    task automatic run_rot(input int p, input int q, input int c, input int s, input bit expect_err);
        int k_done, n_done;
        @(negedge clk);
        bus.rot_valid = 1'b1;
        bus.p = 2'(p);
        bus.q = 2'(q);
        bus.cos = SIZE'(c);
        bus.sin = SIZE'(s);
        @(negedge clk);
        bus.rot_valid = 1'b0;
        checks++;
        if (bus.err !== expect_err) begin
            errors++;
            $display("FAIL err_pulse: got %b, expected %b", bus.err, expect_err);
        end
        k_done = -1;
        n_done = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++;
                if (bus.err !== 1'b0) begin
                    errors++;
                    $display("FAIL err_width: got %b one cycle later, expected 0", bus.err);
                end
            end
            if (k == 2 && !expect_err) begin
                checks++;
                if (bus.rot_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_in_rot: got %b, expected 0", bus.rot_ready);
                end
            end
            if (bus.done === 1'b1) begin
                n_done++;
                if (k_done < 0) k_done = k;
            end
        end
        if (!expect_err) model_rotate(p, q, c, s);
        checks++;
        if (k_done !== (expect_err ? -1 : N + 1)) begin
            errors++;
            $display("FAIL done_latency: got %0d, expected %0d", k_done, expect_err ? -1 : N + 1);
        end
        checks++;
        if (n_done !== (expect_err ? 0 : 1)) begin
            errors++;
            $display("FAIL done_count: got %0d, expected %0d", n_done, expect_err ? 0 : 1);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.q_out, bus.q_valid, bus.done, bus.err, bus.finish, bus.rot_ready} !== {16'h0, 5'b00001}) begin
            errors++;
            $display("FAIL reset_outputs: got q_out=%h v=%b d=%b e=%b f=%b r=%b, expected 0,0,0,0,0,1",
                     bus.q_out, bus.q_valid, bus.done, bus.err, bus.finish, bus.rot_ready);
        end
        rst = 1'b0;
        model_identity();
        run_read("reset_identity");
    endtask

    task automatic test_rot_half();
        do_init();
        run_rot(0, 1, 16'sh0B50, 16'sh0B50, 1'b0);
        run_read("rot_half");
    endtask

    task automatic test_rot_quarter();
        do_init();
        run_rot(0, 1, 0, 16'sh1000, 1'b0);
        run_rot(0, 1, 0, 16'sh1000, 1'b0);
        run_read("rot_quarter");
    endtask

    task automatic test_err();
        do_init();
        run_rot(2, 2, 16'sh0B50, 16'sh0B50, 1'b1);
        run_read("err_identity");
    endtask

    task automatic test_saturate();
        do_init();
        run_rot(0, 1, 32767, 32767, 1'b0);
        run_rot(0, 1, 32767, 32767, 1'b0);
        run_read("saturate");
    endtask

    task automatic test_priority();
        int n_evt;
        @(negedge clk);
        bus.init = 1'b1;
        bus.rot_valid = 1'b1;
        bus.read = 1'b1;
        bus.p = 2'd0;
        bus.q = 2'd1;
        bus.cos = '0;
        bus.sin = 16'sh1000;
        @(negedge clk);
        bus.init = 1'b0;
        bus.rot_valid = 1'b0;
        bus.read = 1'b0;
        model_identity();
        n_evt = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.done === 1'b1 || bus.err === 1'b1 || bus.q_valid === 1'b1) n_evt++;
            @(negedge clk);
        end
        checks++;
        if (n_evt !== 0) begin
            errors++;
            $display("FAIL priority_drop: got %0d event cycles, expected 0", n_evt);
        end
        run_read("priority_identity");
    endtask

    task automatic test_reset_mid_rot();
        @(negedge clk);
        bus.rot_valid = 1'b1;
        bus.p = 2'd0;
        bus.q = 2'd1;
        bus.cos = 16'sh0B50;
        bus.sin = 16'sh0B50;
        @(negedge clk);
        bus.rot_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({bus.q_out, bus.q_valid, bus.done, bus.err, bus.finish, bus.rot_ready} !== {16'h0, 5'b00001}) begin
            errors++;
            $display("FAIL midrot_reset: got q_out=%h v=%b d=%b e=%b f=%b r=%b, expected 0,0,0,0,0,1",
                     bus.q_out, bus.q_valid, bus.done, bus.err, bus.finish, bus.rot_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_identity();
        run_read("midrot_identity");
    endtask

    task automatic test_back_to_back();
        int pa, qa, ca, sa, pb, qb, cb, sb, first, second, n_done;
        do_init();
        for (int round = 0; round < 2; round++) begin
            pa = $urandom_range(0, N - 1);
            qa = (pa + $urandom_range(1, N - 1)) % N;
            ca = int'($urandom_range(0, 65535)) - 32768;
            sa = int'($urandom_range(0, 65535)) - 32768;
            pb = $urandom_range(0, N - 1);
            qb = (pb + $urandom_range(1, N - 1)) % N;
            cb = int'($urandom_range(0, 65535)) - 32768;
            sb = int'($urandom_range(0, 65535)) - 32768;
            @(negedge clk);
            bus.rot_valid = 1'b1;
            bus.p = 2'(pa);
            bus.q = 2'(qa);
            bus.cos = SIZE'(ca);
            bus.sin = SIZE'(sa);
            @(negedge clk);
            bus.p = 2'(pb);
            bus.q = 2'(qb);
            bus.cos = SIZE'(cb);
            bus.sin = SIZE'(sb);
            first = -1;
            second = -1;
            n_done = 0;
            for (int k = 1; k <= 16; k++) begin
                @(negedge clk);
                if (k == N + 2) bus.rot_valid = 1'b0;
                if (bus.done === 1'b1) begin
                    n_done++;
                    if (first < 0) first = k;
                    else if (second < 0) second = k;
                end
            end
            model_rotate(pa, qa, ca, sa);
            model_rotate(pb, qb, cb, sb);
            checks++;
            if (first !== N + 1 || second !== 2 * N + 3 || n_done !== 2) begin
                errors++;
                $display("FAIL b2b_done: got first=%0d second=%0d count=%0d, expected %0d %0d 2",
                         first, second, n_done, N + 1, 2 * N + 3);
            end
        end
        run_read("back_to_back");
    endtask

    initial begin
        rst = 1'b1;
        bus.init = 1'b0;
        bus.rot_valid = 1'b0;
        bus.read = 1'b0;
        bus.p = '0;
        bus.q = '0;
        bus.cos = '0;
        bus.sin = '0;
        test_reset();
        test_rot_half();
        test_rot_quarter();
        test_err();
        test_saturate();
        test_priority();
        test_reset_mid_rot();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire

// File: doc/givens_q_accum.md
GIVENS_Q_ACCUM -- requirements
Module: givens_q_accum

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (N x N, N >= 2).
REQ-002 SHALL have parameter SIZE, default 16, meaning signed word width of cos, sin and Q elements.
REQ-003 SHALL have parameter FRAC, default 12, meaning fractional bits of all fixed-point values (FRAC < SIZE).
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-006 SHALL have port init  in  1  meaning load identity into the matrix.
REQ-007 SHALL have port rot_valid  in  1  meaning a rotation request is present.
REQ-008 SHALL have port rot_ready  out  1  meaning the block can accept a rotation.
REQ-009 SHALL have ports p, q  in  $clog2(N) each  meaning the rotation plane column indices.
REQ-010 SHALL have ports cos, sin  in  SIZE each, signed  meaning rotation coefficients in Q(SIZE-FRAC).FRAC.
REQ-011 SHALL have port read  in  1  meaning start a row-major readout.
REQ-012 SHALL have port done  out  1  meaning a one-cycle pulse when a rotation finishes.
REQ-013 SHALL have port err  out  1  meaning a one-cycle pulse when a rotation request is rejected.
REQ-014 SHALL have port q_out  out  SIZE, signed  meaning the streamed matrix element.
REQ-015 SHALL have port q_valid  out  1  meaning q_out holds a valid element.
REQ-016 SHALL have port finish  out  1  meaning a pulse coincident with the last streamed element.

Function
REQ-017 SHALL implement FSM states IDLE, ROT and READ; rot_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, events SHALL be served in the priority order init > rotation handshake > read; lower-priority requests in the same cycle are dropped.
REQ-019 init in IDLE SHALL set Q to identity (diagonal 2^FRAC, all other elements 0) in one cycle; init in ROT or READ SHALL be ignored.
REQ-020 A rotation SHALL be accepted when rot_valid and rot_ready are both 1; p, q, cos and sin SHALL be captured on that edge.
REQ-021 If p == q, p >= N or q >= N at acceptance, the block SHALL pulse err for one cycle, leave Q unchanged and stay in IDLE.
REQ-022 In ROT, the block SHALL process one row r per cycle for r = 0..N-1, computing Q[r][p] <= c*Q[r][p] - s*Q[r][q] and Q[r][q] <= s*Q[r][p] + c*Q[r][q] from the pre-update values.
REQ-023 Each sum of products SHALL be formed at full 2*SIZE+1 width, arithmetically shifted right by FRAC (floor), and saturated to the signed SIZE range.
REQ-024 Columns other than p and q SHALL remain unchanged.
REQ-025 done SHALL pulse in the cycle after row N-1 is written (acceptance edge t gives done at t+N+1); the FSM SHALL return to IDLE on the same edge.
REQ-026 read in IDLE SHALL stream the N*N elements in row-major order, one per cycle starting the next cycle, with q_valid high for exactly N*N cycles.
REQ-027 finish SHALL pulse together with element [N-1][N-1]; the FSM SHALL then return to IDLE and q_out SHALL hold the last element.
REQ-028 read, rot_valid and init outside IDLE SHALL have no effect and SHALL NOT be queued.
REQ-029 done, err, finish and q_valid SHALL be registered outputs.

Reset
REQ-030 On rst, all outputs SHALL be driven asynchronously to: q_out=0, q_valid=0, done=0, err=0, finish=0, rot_ready=1; the FSM SHALL go to IDLE and row/element counters SHALL clear to 0.
REQ-031 On rst, Q SHALL be set to identity, including when reset is asserted mid-ROT or mid-READ; no partial rotation SHALL persist.

Verification
REQ-032 Reset, then read with N=4 -> 16 q_valid cycles; diagonal elements 0x1000, all others 0; finish pulses on the 16th.
REQ-033 init, then rotation with p=0, q=1, cos=sin=0x0B50 -> done pulses 5 cycles after acceptance; read gives Q[0][0]=0x0B50, Q[0][1]=0x0B50, Q[1][0]=0xF4B0, Q[1][1]=0x0B50, rows 2-3 unchanged.
REQ-034 Two rotations with cos=0, sin=0x1000, p=0, q=1 -> Q[0][0]=0xF000, Q[1][1]=0xF000, Q[0][1]=Q[1][0]=0.
REQ-035 Rotation with p=q=2 -> err pulses for one cycle, no done, and the readout still equals identity.
REQ-036 cos=sin=0x7FFF applied twice on (0,1) from identity -> Q[0][1] saturates to 0x7FFF and Q[0][0]=0.
REQ-037 rst asserted 2 cycles into ROT -> all outputs at reset values immediately; the subsequent readout equals identity.
